// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared widths and types for the register-write scoreboard
package sb_pkg;
    localparam int ADDR_W  = 5;
    localparam int NREGS   = 1 << ADDR_W;
    localparam int CNT_W   = 2;
    localparam int INFL_W  = ADDR_W + CNT_W;
    localparam int XZR_IDX = NREGS - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  pend_cnt_t;
endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - per-register pending-write counter with busy and underflow indication
module sb_entry
    import sb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_underflow
);
    logic [CNT_W-1:0] r_cnt;

    // A simultaneous inc and dec cancels, so it can neither saturate nor underflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_busy      = (r_cnt != '0);
    assign o_underflow = i_dec && !i_inc && (r_cnt == '0);
endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - issue-stage register scoreboard; SCOREBOARD_XZR_EN makes X31 hardwired zero
module reg_scoreboard
    import sb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_issue_valid,
    input  logic              i_issue_wr,
    input  logic [ADDR_W-1:0] i_issue_rd,
    input  logic [ADDR_W-1:0] i_issue_rn,
    input  logic [ADDR_W-1:0] i_issue_rm,
    output logic              o_issue_ready,
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_rd,
    output logic [NREGS-1:0]  o_busy_vec,
    output logic [INFL_W-1:0] o_inflight,
    output logic              o_err_underflow
);
`ifdef SCOREBOARD_XZR_EN
    localparam logic [NREGS-1:0] TRACK_MASK = ~(NREGS'(1) << XZR_IDX);
`else
    localparam logic [NREGS-1:0] TRACK_MASK = '1;
`endif

    logic [NREGS-1:0][CNT_W-1:0] w_cnt;
    logic [NREGS-1:0]            w_busy;
    logic [NREGS-1:0]            w_uflow;
    logic [NREGS-1:0]            w_inc;
    logic [NREGS-1:0]            w_dec;
    logic                        w_accept;
    logic                        w_up;
    logic                        w_down;
    logic [INFL_W-1:0]           r_inflight;
    logic                        r_err;

    // Readiness looks only at registered counts; a same-cycle writeback is not bypassed.
    assign o_issue_ready = !w_busy[i_issue_rn] && !w_busy[i_issue_rm] &&
                           !(i_issue_wr && w_cnt[i_issue_rd] == CNT_MAX);
    assign w_accept = i_issue_valid && o_issue_ready;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_inc[i] = w_accept && i_issue_wr && (i_issue_rd == ADDR_W'(i));
            w_dec[i] = i_wb_valid && (i_wb_rd == ADDR_W'(i));
        end
        w_inc = w_inc & TRACK_MASK;
        w_dec = w_dec & TRACK_MASK;
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_entry
        sb_entry u_entry (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_inc       (w_inc[g]),
            .i_dec       (w_dec[g]),
            .o_cnt       (w_cnt[g]),
            .o_busy      (w_busy[g]),
            .o_underflow (w_uflow[g])
        );
    end

    // At most one register increments and one decrements per cycle.
    assign w_up   = |(w_inc & ~w_dec);
    assign w_down = |(w_dec & ~w_inc & w_busy);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= r_inflight + INFL_W'(w_up) - INFL_W'(w_down);
            if (|w_uflow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_busy_vec      = w_busy;
    assign o_inflight      = r_inflight;
    assign o_err_underflow = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed and randomized checks of reg_scoreboard against a counting model
module tb_reg_scoreboard;
    import sb_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_wr = 1'b0;
    logic [ADDR_W-1:0] issue_rd = '0;
    logic [ADDR_W-1:0] issue_rn = '0;
    logic [ADDR_W-1:0] issue_rm = '0;
    logic              issue_ready;
    logic              wb_valid = 1'b0;
    logic [ADDR_W-1:0] wb_rd = '0;
    logic [NREGS-1:0]  busy_vec;
    logic [INFL_W-1:0] inflight;
    logic              err_underflow;

    int checks = 0;
    int errors = 0;

    int m_cnt[NREGS];
    int m_infl;
    bit m_err;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_issue_valid   (issue_valid),
        .i_issue_wr      (issue_wr),
        .i_issue_rd      (issue_rd),
        .i_issue_rn      (issue_rn),
        .i_issue_rm      (issue_rm),
        .o_issue_ready   (issue_ready),
        .i_wb_valid      (wb_valid),
        .i_wb_rd         (wb_rd),
        .o_busy_vec      (busy_vec),
        .o_inflight      (inflight),
        .o_err_underflow (err_underflow)
    );

    function automatic bit tracked(int r);
`ifdef SCOREBOARD_XZR_EN
        return r != XZR_IDX;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit model_ready(bit wr, int rd, int rn, int rm);
        return m_cnt[rn] == 0 && m_cnt[rm] == 0 && !(wr && m_cnt[rd] == 3);
    endfunction

    function automatic logic [NREGS-1:0] model_busy();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = (m_cnt[i] > 0);
        return v;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(string tag);
        chk({tag, "_busy"}, 64'(busy_vec), 64'(model_busy()));
        chk({tag, "_inflight"}, 64'(inflight), 64'(m_infl));
        chk({tag, "_err"}, 64'(err_underflow), 64'(m_err));
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
        m_infl = 0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        issue_valid = 1'b0;
        wb_valid = 1'b0;
        model_clear();
        #1;
        check_state("rst");
        chk("rst_ready", 64'(issue_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive, check combinational readiness, clock, advance the model, check state.
    task automatic step(bit v, bit wr, int rd, int rn, int rm, bit wv, int wrd);
        bit rdy;
        bit inc;
        bit dec;
        @(negedge clk);
        issue_valid = v;
        issue_wr = wr;
        issue_rd = ADDR_W'(rd);
        issue_rn = ADDR_W'(rn);
        issue_rm = ADDR_W'(rm);
        wb_valid = wv;
        wb_rd = ADDR_W'(wrd);
        #1;
        rdy = model_ready(wr, rd, rn, rm);
        chk("issue_ready", 64'(issue_ready), 64'(rdy));
        @(posedge clk);
        inc = v && rdy && wr && tracked(rd);
        dec = wv && tracked(wrd);
        if (inc && dec && rd == wrd) begin
        end else begin
            if (inc) begin
                m_cnt[rd]++;
                m_infl++;
            end
            if (dec) begin
                if (m_cnt[wrd] == 0) m_err = 1'b1;
                else begin
                    m_cnt[wrd]--;
                    m_infl--;
                end
            end
        end
        #1;
        check_state("step");
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int pick_reg();
        int r = int'($urandom_range(0, 9));
        return (r > 7) ? XZR_IDX : r;
    endfunction

    initial begin
        model_clear();
        do_reset();
        idle();

        // RAW hazard on x3 and its release by writeback
        step(1, 1, 3, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0, 0, 0);
        step(1, 0, 0, 3, 0, 1, 3);
        step(1, 0, 0, 3, 0, 0, 0);

        // saturate x7, then a fourth writer stalls while x8 proceeds
        step(1, 1, 7, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0);
        step(1, 1, 8, 0, 0, 0, 0);
        // writer to x7 at max alongside a x7 writeback: still stalled, count drops
        step(1, 1, 7, 0, 0, 1, 7);

        // same-cycle issue and writeback on x5
        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 1, 5);
        chk("x5_cnt", 64'(busy_vec[5]), 64'(1));

        // underflow on x9 is sticky until reset
        step(0, 0, 0, 0, 0, 1, 9);
        idle();
        idle();
        do_reset();
        idle();

        // zero-register handling
        step(1, 1, 31, 0, 0, 0, 0);
        step(1, 0, 0, 31, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 31);
        step(0, 0, 0, 0, 0, 1, 31);

        do_reset();
        for (int n = 0; n < 600; n++) begin
            int wrd;
            bit wv;
            wv = ($urandom_range(0, 2) != 0);
            wrd = pick_reg();
            if ($urandom_range(0, 7) != 0) begin
                for (int k = 0; k < 4; k++) begin
                    int c = pick_reg();
                    if (m_cnt[c] > 0) wrd = c;
                end
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 pick_reg(), pick_reg(), pick_reg(), wv, wrd);
            if (n % 150 == 149) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
